// File: rtl/seg_pkg.sv
// Shared definitions for 7-segment display paths.
// Glyphs are 7 bits ordered {a,b,c,d,e,f,g}, active-high (a is bit 6, g is bit 0).
// Pure constants, no logic.
package seg_pkg;

    // Bit positions of each segment inside a 7-bit glyph
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

endpackage

// File: rtl/hex_to_seg.sv
// Purpose: decode one hex nibble to a 7-segment glyph {a..g}, active-high.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports: nibble (4-bit value 0..F) in, seg (7-bit glyph) out.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Purpose: time-multiplexed multi-digit 7-segment driver with frame-aligned (tear-free) updates.
// Latency: seg/an registered, one cycle after idx/disp/en; a load shows within DIGITS*REFRESH_DIV+1 cycles.
// Backpressure: load_ready = !pending; one update is held until the next frame boundary commits it.
// Ports: clk, rst (sync, active-high); load_valid/load_ready/load_data (packed nibbles, digit 0 rightmost);
//        en (display enable); seg {a..g} and one-hot an, both registered, active-high.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LEAD_BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic                  en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                tick;
    logic                frame_end;
    logic                accept;
    logic [3:0]          nib;
    logic [6:0]          glyph;
    logic [DIGITS-1:0]   blank_vec;
    logic                zero_above;

    assign tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_end  = tick && (idx_q == IDX_W'(DIGITS - 1));
    assign load_ready = !pending_q;
    assign accept     = load_valid && !pending_q;

    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nib),
        .seg    (glyph)
    );

    // Walk from the most significant digit down; a digit is a leading zero
    // when it and every digit above it are zero. Digit 0 always shows.
    always_comb begin
        blank_vec  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (disp_q[4*i +: 4] == 4'h0);
            blank_vec[i] = (LEAD_BLANK != 0) && (i > 0) && zero_above;
        end
    end

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        disp_d    = disp_q;

        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // Commit uses the pre-edge pending flag; an accept can only happen
        // while pending is clear, so the two branches never overlap.
        if (frame_end && pending_q) begin
            disp_d    = pend_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            pend_d    = load_data;
            pending_d = 1'b1;
        end

        an_d = '0;
        if (en) begin
            an_d[idx_q] = 1'b1;
        end
        seg_d = (en && !blank_vec[idx_q]) ? glyph : SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            pend_q    <= '0;
            disp_q    <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, REFRESH_DIV=4.
// Cycle k counts rising edges since reset release (k=0 is the first edge with rst low);
// the frame boundary edge is k = 15 mod 16, and a new frame is visible from k = 16m.
module tb_seg_scan_driver;

    localparam logic [6:0] G0   = 7'b1111110;
    localparam logic [6:0] G1   = 7'b0110000;
    localparam logic [6:0] G2   = 7'b1101101;
    localparam logic [6:0] G3   = 7'b1111001;
    localparam logic [6:0] G4   = 7'b0110011;
    localparam logic [6:0] G5   = 7'b1011011;
    localparam logic [6:0] G7   = 7'b1110000;
    localparam logic [6:0] GA   = 7'b1110111;
    localparam logic [6:0] GF   = 7'b1000111;
    localparam logic [6:0] GOFF = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;
    logic        en;
    logic        load_ready, load_ready_nb;
    logic [6:0]  seg, seg_nb;
    logic [3:0]  an, an_nb;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    logic [3:0] an_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .LEAD_BLANK(1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .en(en), .seg(seg), .an(an)
    );

    seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .LEAD_BLANK(0)) dut_nb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_nb),
        .load_data(load_data), .en(en), .seg(seg_nb), .an(an_nb)
    );

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_k(input int target);
        while (k < target) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        k = -1;
    endtask

    task automatic test_reset();
        load_valid = 1'b0;
        load_data  = 16'h0;
        en         = 1'b1;
        do_reset();
        checks++; if (an !== 4'b0000) begin errors++; $display("FAIL reset_an got %b want 0000", an); end
        checks++; if (seg !== GOFF) begin errors++; $display("FAIL reset_seg got %b want %b", seg, GOFF); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", load_ready); end
    endtask

    // Frame 0 (k=0..15): blank display shows "0" on digit 0 only.
    task automatic test_idle();
        for (int s = 0; s < 4; s++) begin
            wait_k(4 * s);
            checks++; if (an !== an_tab[s]) begin errors++; $display("FAIL idle_an slot %0d got %b want %b", s, an, an_tab[s]); end
            checks++; if (seg !== ((s == 0) ? G0 : GOFF)) begin errors++; $display("FAIL idle_seg slot %0d got %b", s, seg); end
            checks++; if (seg_nb !== G0) begin errors++; $display("FAIL idle_seg_noblank slot %0d got %b want %b", s, seg_nb, G0); end
            wait_k(4 * s + 3);
            checks++; if (an !== an_tab[s]) begin errors++; $display("FAIL idle_hold slot %0d got %b want %b", s, an, an_tab[s]); end
        end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", load_ready); end
    endtask

    // Accept 12AF at edge 21 (mid frame 1), commit at edge 31, visible in frame 2.
    task automatic test_load_commit();
        logic [6:0] exp_tab [4] = '{GF, GA, G2, G1};
        wait_k(20);
        load_valid = 1'b1;
        load_data  = 16'h12AF;
        step();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL lc_ready_drop got %b want 0", load_ready); end
        wait_k(30);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL lc_ready_hold got %b want 0", load_ready); end
        wait_k(31);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL lc_ready_rise got %b want 1", load_ready); end
        checks++; if (seg !== GOFF) begin errors++; $display("FAIL lc_no_tear got %b want %b", seg, GOFF); end
        for (int s = 0; s < 4; s++) begin
            wait_k(32 + 4 * s);
            checks++; if (an !== an_tab[s]) begin errors++; $display("FAIL lc_an slot %0d got %b want %b", s, an, an_tab[s]); end
            checks++; if (seg !== exp_tab[s]) begin errors++; $display("FAIL lc_seg slot %0d got %b want %b", s, seg, exp_tab[s]); end
        end
    endtask

    // 0003 accepted at edge 34; 0004 held valid is refused until ready returns after edge 47.
    task automatic test_back_to_back();
        wait_k(33);
        load_valid = 1'b1;
        load_data  = 16'h0003;
        step();
        load_data  = 16'h0004;
        step();
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", load_ready); end
        wait_k(47);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b want 1", load_ready); end
        step();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got %b want 0", load_ready); end
        checks++; if (seg !== G3) begin errors++; $display("FAIL bp_show3 got %b want %b", seg, G3); end
        wait_k(52);
        checks++; if (seg !== GOFF) begin errors++; $display("FAIL bp_blank1 got %b want %b", seg, GOFF); end
        wait_k(64);
        checks++; if (seg !== G4) begin errors++; $display("FAIL bp_show4 got %b want %b", seg, G4); end
    endtask

    // 0050 accepted at edge 66, visible in frame k=80..95 on both instances.
    task automatic test_blanking();
        logic [6:0] exp_b  [4] = '{G0, G5, GOFF, GOFF};
        logic [6:0] exp_nb [4] = '{G0, G5, G0, G0};
        wait_k(65);
        load_valid = 1'b1;
        load_data  = 16'h0050;
        step();
        load_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wait_k(80 + 4 * s);
            checks++; if (seg !== exp_b[s]) begin errors++; $display("FAIL blank_lb1 slot %0d got %b want %b", s, seg, exp_b[s]); end
            checks++; if (seg_nb !== exp_nb[s]) begin errors++; $display("FAIL blank_lb0 slot %0d got %b want %b", s, seg_nb, exp_nb[s]); end
            checks++; if (an !== an_tab[s]) begin errors++; $display("FAIL blank_an slot %0d got %b want %b", s, an, an_tab[s]); end
        end
    endtask

    // Accept exactly on the boundary edge 95: not committed until edge 111.
    task automatic test_boundary_accept();
        wait_k(94);
        load_valid = 1'b1;
        load_data  = 16'h0007;
        step();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL bnd_accept got %b want 0", load_ready); end
        wait_k(96);
        checks++; if (seg !== G0) begin errors++; $display("FAIL bnd_no_commit got %b want %b", seg, G0); end
        wait_k(100);
        checks++; if (seg !== G5) begin errors++; $display("FAIL bnd_old_digit1 got %b want %b", seg, G5); end
        wait_k(110);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL bnd_ready_hold got %b want 0", load_ready); end
        wait_k(111);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready_rise got %b want 1", load_ready); end
        wait_k(112);
        checks++; if (seg !== G7) begin errors++; $display("FAIL bnd_commit got %b want %b", seg, G7); end
    endtask

    task automatic test_en_reset();
        wait_k(113);
        en = 1'b0;
        step();
        checks++; if (an !== 4'b0000) begin errors++; $display("FAIL en_an_off got %b want 0000", an); end
        checks++; if (seg !== GOFF) begin errors++; $display("FAIL en_seg_off got %b want %b", seg, GOFF); end
        wait_k(123);
        checks++; if (an !== 4'b0000) begin errors++; $display("FAIL en_an_hold got %b want 0000", an); end
        en = 1'b1;
        step();
        checks++; if (an !== 4'b1000) begin errors++; $display("FAIL en_idx_advanced got %b want 1000", an); end
        wait_k(128);
        checks++; if (an !== 4'b0001) begin errors++; $display("FAIL en_resume_an got %b want 0001", an); end
        checks++; if (seg !== G7) begin errors++; $display("FAIL en_resume_seg got %b want %b", seg, G7); end
        load_valid = 1'b1;
        load_data  = 16'h0009;
        step();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_pending_set got %b want 0", load_ready); end
        do_reset();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_pending_clear got %b want 1", load_ready); end
        checks++; if (an !== 4'b0000) begin errors++; $display("FAIL rst_an got %b want 0000", an); end
        wait_k(0);
        checks++; if (an !== 4'b0001) begin errors++; $display("FAIL rst_restart_an got %b want 0001", an); end
        checks++; if (seg !== G0) begin errors++; $display("FAIL rst_display_zero got %b want %b", seg, G0); end
        wait_k(16);
        checks++; if (seg !== G0) begin errors++; $display("FAIL rst_no_late_commit got %b want %b", seg, G0); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", load_ready); end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        en         = 1'b0;
        test_reset();
        test_idle();
        test_load_commit();
        test_back_to_back();
        test_blanking();
        test_boundary_accept();
        test_en_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
